output_buffer: RTL and testbench

Parametrised successor to the single-matrix output register: a DEPTH-entry first-in-first-out buffer of result matrices, with matrix element width and dimensions set by parameters.
Sits between the ALU/matrix datapath and the result consumer; collects finished results and drains them in order.
Uses valid/ready handshakes on both sides and provides occupancy, flush and sticky error reporting.

---
 rtl/output_buffer_pkg.sv | 24 ++
 rtl/output_buffer_mem.sv | 41 ++++
 rtl/output_buffer.sv | 100 ++++++++++
 tb/tb_output_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_buffer_pkg.sv
// Shared sizing defaults and matrix layout helpers for the output buffer.
package output_buffer_pkg;

  localparam int unsigned ELEM_W_DEF = 16;
  localparam int unsigned ROWS_DEF   = 4;
  localparam int unsigned COLS_DEF   = 4;
  localparam int unsigned DEPTH_DEF  = 4;

  // Flattened matrix width for a given element width and shape.
  function automatic int unsigned mat_width(input int unsigned elem_w,
                                            input int unsigned rows,
                                            input int unsigned cols);
    return elem_w * rows * cols;
  endfunction

  // Bit offset of element (r,c) inside a flattened, row-major matrix.
  function automatic int unsigned elem_off(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned cols,
                                           input int unsigned elem_w);
    return (r * cols + c) * elem_w;
  endfunction

endpackage

// File: rtl/output_buffer_mem.sv
// DEPTH x MAT_W storage: one write port, one registered write-first read port.
module output_buffer_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MAT_W = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [MAT_W-1:0] wdata,
  input  logic             re,
  input  logic             rclr,
  input  logic [AW-1:0]    raddr,
  output logic [MAT_W-1:0] rdata
);

  logic [MAT_W-1:0] mem [DEPTH];

  // Storage array, zeroed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register; a same-edge write to the read address is forwarded so a
  // push into an empty buffer shows up one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rclr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/output_buffer.sv
// FIFO of result matrices with valid/ready on both sides, occupancy and sticky errors.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned MAT_W = mat_width(ELEM_W, ROWS, COLS),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [MAT_W-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [MAT_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             full_nxt, empty_nxt, ovf_nxt, und_nxt;
  logic             push, pop, mem_we, mem_re;

  assign wr_ready = ~full;
  assign rd_valid = ~empty;

  // Handshake decode and next-state for pointers, occupancy and flags.
  always_comb begin
    push       = wr_valid & ~full;
    pop        = rd_ready & ~empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    ovf_nxt    = overflow_err | (wr_valid & full);
    und_nxt    = underflow_err | (rd_ready & empty);
    if (clear) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
      und_nxt    = 1'b0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
    end
    full_nxt  = (count_nxt == CNT_W'(DEPTH));
    empty_nxt = (count_nxt == '0);
    mem_we    = push & ~clear;
    mem_re    = ~clear & ~empty_nxt;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      count         <= count_nxt;
      full          <= full_nxt;
      empty         <= empty_nxt;
      overflow_err  <= ovf_nxt;
      underflow_err <= und_nxt;
    end
  end

  output_buffer_mem #(
    .DEPTH (DEPTH),
    .MAT_W (MAT_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (reset),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (mem_re),
    .rclr  (clear),
    .raddr (rd_ptr_nxt),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: vector table, directed corners, random vs queue model.
module tb_output_buffer;
  import output_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAT_W = mat_width(ELEM_W_DEF, ROWS_DEF, COLS_DEF);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef logic [MAT_W-1:0] mat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  mat_t             wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  mat_t             rd_data;
  logic [CNT_W-1:0] count;
  logic             full, empty, overflow_err, underflow_err;

  output_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: an ordered queue of stored matrices plus the visible head.
  mat_t q[$];
  bit   m_ovf, m_und;
  mat_t m_rd;

  typedef struct {
    bit          wv;
    int unsigned wbase;
    bit          rr;
    bit          clr;
    int unsigned e_count;
    bit          e_full;
    bit          e_empty;
    bit          e_ovf;
    bit          e_und;
    int unsigned e_rbase;
  } vec_t;

  vec_t tbl[12];

  // Matrix whose element k (row-major) is base+k; base 0 means the all-zero matrix.
  function automatic mat_t mk_mat(input int unsigned base);
    mat_t m = '0;
    if (base != 0) begin
      for (int unsigned r = 0; r < ROWS_DEF; r++)
        for (int unsigned c = 0; c < COLS_DEF; c++)
          m[elem_off(r, c, COLS_DEF, ELEM_W_DEF) +: ELEM_W_DEF] = ELEM_W_DEF'(base + r * COLS_DEF + c);
    end
    return m;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m = '0;
    for (int unsigned i = 0; i < MAT_W / 32; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_mat(input string nm, input mat_t act, input mat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_und = 1'b0;
    m_rd  = '0;
  endtask

  // Apply one clock edge of the buffer's rules to the model.
  task automatic model_edge(input bit wv, input mat_t wd, input bit rr, input bit clr);
    int  n      = q.size();
    bit  is_full  = (n == int'(DEPTH));
    bit  is_empty = (n == 0);
    if (clr) begin
      model_reset();
    end else begin
      if (wv && is_full) m_ovf = 1'b1;
      if (rr && is_empty) m_und = 1'b1;
      if (rr && !is_empty) void'(q.pop_front());
      if (wv && !is_full) q.push_back(wd);
      if (q.size() > 0) m_rd = q[0];
    end
  endtask

  task automatic check_model(input string tag);
    int n = q.size();
    cmp({tag, ".count"}, 32'(count), 32'(n));
    cmp({tag, ".full"}, 32'(full), 32'(n == int'(DEPTH)));
    cmp({tag, ".empty"}, 32'(empty), 32'(n == 0));
    cmp({tag, ".wr_ready"}, 32'(wr_ready), 32'(n != int'(DEPTH)));
    cmp({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
    cmp({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
    cmp({tag, ".und"}, 32'(underflow_err), 32'(m_und));
    cmp_mat({tag, ".rd_data"}, rd_data, m_rd);
  endtask

  // Drive one cycle of inputs, update the model on the edge, sample 1ns later.
  task automatic step(input bit wv, input mat_t wd, input bit rr, input bit clr);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    clear    = clr;
    @(posedge clk);
    model_edge(wv, wd, rr, clr);
    #1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    clear    = 1'b0;
  endtask

  // Asynchronous reset between edges, checked while held, released on a falling edge.
  task automatic async_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model({tag, ".in_reset"});
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model({tag, ".released"});
  endtask

  initial begin
    mat_t x;
    string tg;
    model_reset();

    tbl[0]  = '{1, 1, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 2, 0, 0, 2, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 3, 0, 0, 3, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 4, 0, 0, 4, 1, 0, 0, 0, 1};
    tbl[4]  = '{1, 5, 0, 0, 4, 1, 0, 1, 0, 1};
    tbl[5]  = '{0, 0, 1, 0, 3, 0, 0, 1, 0, 2};
    tbl[6]  = '{0, 0, 1, 0, 2, 0, 0, 1, 0, 3};
    tbl[7]  = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 4};
    tbl[8]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0, 4};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 4};
    tbl[10] = '{1, 7, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{1, 1, 1, 0, 1, 0, 0, 0, 1, 1};

    // Power-on reset, then a reset that lands in the middle of traffic.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model("por");
    step(1, mk_mat(9), 0, 0);
    step(1, mk_mat(10), 1, 0);
    check_model("pre_reset");
    async_reset("mid_reset");

    // Vector table: fill, overflow, drain, underflow, clear, push into empty.
    foreach (tbl[i]) begin
      step(tbl[i].wv, mk_mat(tbl[i].wbase), tbl[i].rr, tbl[i].clr);
      tg = $sformatf("vec%0d", i);
      cmp({tg, ".count"}, 32'(count), 32'(tbl[i].e_count));
      cmp({tg, ".full"}, 32'(full), 32'(tbl[i].e_full));
      cmp({tg, ".empty"}, 32'(empty), 32'(tbl[i].e_empty));
      cmp({tg, ".wr_ready"}, 32'(wr_ready), 32'(!tbl[i].e_full));
      cmp({tg, ".rd_valid"}, 32'(rd_valid), 32'(!tbl[i].e_empty));
      cmp({tg, ".ovf"}, 32'(overflow_err), 32'(tbl[i].e_ovf));
      cmp({tg, ".und"}, 32'(underflow_err), 32'(tbl[i].e_und));
      cmp_mat({tg, ".rd_data"}, rd_data, mk_mat(tbl[i].e_rbase));
    end
    step(0, '0, 0, 1);
    check_model("post_table_clear");

    // Wrap-around: hold two entries while pushing and popping every cycle.
    step(1, rnd_mat(), 0, 0);
    step(1, rnd_mat(), 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, rnd_mat(), 1, 0);
      check_model($sformatf("wrap%0d", i));
      cmp($sformatf("wrap%0d.hold2", i), 32'(count), 32'd2);
    end
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check_model("wrap_drained");

    // Simultaneous push/pop at count 3; the new entry surfaces after two more pops.
    for (int i = 0; i < 3; i++) step(1, rnd_mat(), 0, 0);
    x = mk_mat(16'h0abc);
    step(1, x, 1, 0);
    check_model("pp3");
    cmp("pp3.hold3", 32'(count), 32'd3);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check_model("pp3_pop2");
    cmp_mat("pp3.new_head", rd_data, x);
    step(0, '0, 1, 0);
    check_model("pp3_empty");

    // Clear wins over a same-cycle push and pop at count 2 with overflow set.
    for (int i = 0; i < 5; i++) step(1, rnd_mat(), 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    check_model("pre_clear");
    step(1, rnd_mat(), 1, 1);
    check_model("clear");
    cmp_mat("clear.rd_zero", rd_data, '0);
    step(0, '0, 0, 0);
    check_model("after_clear");

    // Random traffic: fill-biased phase then drain-biased phase, rare clears, one reset.
    for (int i = 0; i < 400; i++) begin
      bit wv, rr, clr;
      if (i < 200) begin
        wv = ($urandom_range(0, 3) != 0);
        rr = ($urandom_range(0, 1) != 0);
      end else begin
        wv = ($urandom_range(0, 1) != 0);
        rr = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 39) == 0);
      step(wv, rnd_mat(), rr, clr);
      check_model($sformatf("rnd%0d", i));
      if (i == 250) async_reset("rnd_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
